// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
// Shares one single-ported unified instruction/data RAM between the IF stage
// (instruction fetch) and the MEM stage (lw/sw). Data accesses win over fetches.
// A fetch that is already in flight always finishes before data is served.
// Each completed result is held in a buffer. A combinational stall freezes the
// pipeline until every access of the current instruction pair is complete.
// A watchdog bounds each RAM access.
//
// Ports:
//   clk, rst                  clock, asynchronous active-low reset
//   if_req/if_addr/if_flush   fetch request (level), PC, discard in-flight fetch
//   if_rdata                  buffered instruction
//   mem_rd/mem_wr/mem_addr/mem_wdata  load/store request (level), address, store data
//   mem_rdata                 buffered load data
//   ram_en/ram_we/ram_addr/ram_wdata  RAM command (ram_en is a 1-cycle strobe)
//   ram_rdata/ram_done        RAM read data, qualified by the completion pulse
//   stall                     pipeline freeze (combinational)
//   timeout_err               sticky watchdog flag
module mem_port_arbiter #(
    parameter int          MAX_WAIT     = 15,
    parameter logic [31:0] TIMEOUT_DATA = 32'hDEADBEEF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    input  logic        if_flush,
    output logic [31:0] if_rdata,
    input  logic        mem_rd,
    input  logic        mem_wr,
    input  logic [31:0] mem_addr,
    input  logic [31:0] mem_wdata,
    output logic [31:0] mem_rdata,
    output logic        ram_en,
    output logic        ram_we,
    output logic [31:0] ram_addr,
    output logic [31:0] ram_wdata,
    input  logic [31:0] ram_rdata,
    input  logic        ram_done,
    output logic        stall,
    output logic        timeout_err
);

    localparam int CW = $clog2(MAX_WAIT + 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DATA  = 2'd1,
        FETCH = 2'd2
    } state_t;

    state_t        state_r;
    state_t        state_nxt_s;
    logic          data_done_r;
    logic          fetch_done_r;
    logic          flush_seen_r;
    logic [CW-1:0] wd_cnt_r;
    logic          ram_en_r;
    logic          ram_we_r;
    logic [31:0]   ram_addr_r;
    logic [31:0]   ram_wdata_r;
    logic [31:0]   if_rdata_r;
    logic [31:0]   mem_rdata_r;
    logic          timeout_err_r;

    logic          data_pend_s;
    logic          fetch_pend_s;
    logic          stall_s;
    logic          advance_s;
    logic          timeout_s;
    logic          complete_s;
    logic [31:0]   cpl_data_s;
    logic          issue_data_s;
    logic          issue_fetch_s;
    logic          data_cpl_s;
    logic          fetch_cpl_s;
    logic          fetch_keep_s;
    logic          in_access_s;

    // Pending/stall/advance decode and access completion (real or watchdog)
    always_comb begin
        data_pend_s  = (mem_rd | mem_wr) & ~data_done_r;
        fetch_pend_s = if_req & ~fetch_done_r & ~if_flush;
        // Stall ignores if_flush so a flushed fetch keeps the pipeline frozen
        stall_s      = data_pend_s | (if_req & ~fetch_done_r);
        advance_s    = ~stall_s & (if_req | mem_rd | mem_wr);
        // A real ram_done on the limit cycle wins over the timeout
        timeout_s    = (wd_cnt_r == CW'(MAX_WAIT)) & ~ram_done;
        complete_s   = ram_done | timeout_s;
        cpl_data_s   = timeout_s ? TIMEOUT_DATA : ram_rdata;
    end

    // FSM state register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // FSM next-state logic: data first, no preemption, no issue on an advance cycle
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            IDLE: begin
                if (advance_s) begin
                    state_nxt_s = IDLE;
                end else if (data_pend_s) begin
                    state_nxt_s = DATA;
                end else if (fetch_pend_s) begin
                    state_nxt_s = FETCH;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            DATA, FETCH: begin
                if (complete_s) begin
                    state_nxt_s = IDLE;
                end else begin
                    state_nxt_s = state_r;
                end
            end
            default: state_nxt_s = IDLE;
        endcase
    end

    // FSM output decode: issue and completion strobes for the datapath
    always_comb begin
        issue_data_s  = 1'b0;
        issue_fetch_s = 1'b0;
        data_cpl_s    = 1'b0;
        fetch_cpl_s   = 1'b0;
        fetch_keep_s  = 1'b0;
        in_access_s   = 1'b0;
        case (state_r)
            IDLE: begin
                if (!advance_s && data_pend_s) begin
                    issue_data_s = 1'b1;
                end else if (!advance_s && fetch_pend_s) begin
                    issue_fetch_s = 1'b1;
                end else begin
                    issue_data_s  = 1'b0;
                    issue_fetch_s = 1'b0;
                end
            end
            DATA: begin
                in_access_s = 1'b1;
                data_cpl_s  = complete_s;
            end
            FETCH: begin
                in_access_s  = 1'b1;
                fetch_cpl_s  = complete_s;
                // A flush seen at any cycle of this fetch, including this one, drops it
                fetch_keep_s = ~flush_seen_r & ~if_flush;
            end
            default: begin
                in_access_s = 1'b0;
            end
        endcase
    end

    // RAM command, watchdog counter, flush tracking and result buffers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ram_en_r      <= 1'b0;
            ram_we_r      <= 1'b0;
            ram_addr_r    <= 32'd0;
            ram_wdata_r   <= 32'd0;
            wd_cnt_r      <= '0;
            flush_seen_r  <= 1'b0;
            if_rdata_r    <= 32'd0;
            mem_rdata_r   <= 32'd0;
            timeout_err_r <= 1'b0;
        end else begin
            ram_en_r <= issue_data_s | issue_fetch_s;
            if (issue_data_s) begin
                ram_addr_r   <= mem_addr;
                ram_wdata_r  <= mem_wdata;
                ram_we_r     <= mem_wr;
                wd_cnt_r     <= '0;
                flush_seen_r <= 1'b0;
            end else if (issue_fetch_s) begin
                ram_addr_r   <= if_addr;
                ram_we_r     <= 1'b0;
                wd_cnt_r     <= '0;
                flush_seen_r <= 1'b0;
            end else if (in_access_s) begin
                if (!complete_s) begin
                    wd_cnt_r <= wd_cnt_r + CW'(1);
                end
                if (if_flush) begin
                    flush_seen_r <= 1'b1;
                end
            end
            if (data_cpl_s && !ram_we_r) begin
                mem_rdata_r <= cpl_data_s;
            end
            if (fetch_cpl_s && fetch_keep_s) begin
                if_rdata_r <= cpl_data_s;
            end
            if (in_access_s && timeout_s) begin
                timeout_err_r <= 1'b1;
            end
        end
    end

    // Completion flags: cleared on advance; a flush also invalidates a held fetch
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            data_done_r  <= 1'b0;
            fetch_done_r <= 1'b0;
        end else begin
            if (advance_s) begin
                data_done_r <= 1'b0;
            end else if (data_cpl_s) begin
                data_done_r <= 1'b1;
            end
            if (advance_s || if_flush) begin
                fetch_done_r <= 1'b0;
            end else if (fetch_cpl_s && fetch_keep_s) begin
                fetch_done_r <= 1'b1;
            end
        end
    end

    assign ram_en      = ram_en_r;
    assign ram_we      = ram_we_r;
    assign ram_addr    = ram_addr_r;
    assign ram_wdata   = ram_wdata_r;
    assign if_rdata    = if_rdata_r;
    assign mem_rdata   = mem_rdata_r;
    assign timeout_err = timeout_err_r;
    assign stall       = stall_s;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter. A RAM responder pops the expected
// RAM commands (address, write enable, data, issue cycle, latency) when ram_en
// appears. Result expectations are popped when the pipeline stall drops.
module tb_mem_port_arbiter;

    logic        clk;
    logic        rst;
    logic        if_req;
    logic [31:0] if_addr;
    logic        if_flush;
    logic [31:0] if_rdata;
    logic        mem_rd;
    logic        mem_wr;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        ram_en;
    logic        ram_we;
    logic [31:0] ram_addr;
    logic [31:0] ram_wdata;
    logic [31:0] ram_rdata;
    logic        ram_done;
    logic        stall;
    logic        timeout_err;

    typedef struct {
        logic [31:0] addr;
        logic        we;
        logic [31:0] wdata;
        int          cyc;
        int          lat;
    } cmd_t;

    typedef struct {
        string       tag;
        int          kind;   // 0 if_rdata, 1 mem_rdata, 2 timeout_err, 3 stall-low cycle
        logic [31:0] val;
    } res_t;

    cmd_t        cmd_q[$];
    res_t        res_q[$];
    logic [31:0] ram_mem [logic [31:0]];
    int          cyc = 0;
    int          n_cmp = 0;
    int          n_err = 0;
    int          n_start;
    int          low_cyc;

    mem_port_arbiter #(.MAX_WAIT(15), .TIMEOUT_DATA(32'hDEADBEEF)) dut (
        .clk        (clk),
        .rst        (rst),
        .if_req     (if_req),
        .if_addr    (if_addr),
        .if_flush   (if_flush),
        .if_rdata   (if_rdata),
        .mem_rd     (mem_rd),
        .mem_wr     (mem_wr),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata),
        .ram_en     (ram_en),
        .ram_we     (ram_we),
        .ram_addr   (ram_addr),
        .ram_wdata  (ram_wdata),
        .ram_rdata  (ram_rdata),
        .ram_done   (ram_done),
        .stall      (stall),
        .timeout_err(timeout_err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Cycle index: number of rising edges seen so far
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] ram_read(input logic [31:0] a);
        if (ram_mem.exists(a)) return ram_mem[a];
        return ~a;
    endfunction

    task automatic exp_cmd(input logic [31:0] a, input logic we, input logic [31:0] wd,
                           input int c, input int lat);
        cmd_t e;
        e.addr = a; e.we = we; e.wdata = wd; e.cyc = c; e.lat = lat;
        cmd_q.push_back(e);
    endtask

    task automatic exp_res(input string tag, input int kind, input logic [31:0] v);
        res_t r;
        r.tag = tag; r.kind = kind; r.val = v;
        res_q.push_back(r);
    endtask

    // Drive one instruction's requests just after a rising edge
    task automatic drive(input logic rd, input logic wr, input logic ifr,
                         input logic [31:0] ia, input logic [31:0] ma, input logic [31:0] wd);
        @(posedge clk);
        #1;
        mem_rd = rd; mem_wr = wr; if_req = ifr;
        if_addr = ia; mem_addr = ma; mem_wdata = wd;
        n_start = cyc;
    endtask

    // Wait (bounded) for stall to drop, then pop and check all expected results
    task automatic wait_done();
        res_t r;
        for (int i = 0; i < 80; i++) begin
            @(negedge clk);
            if (!stall) break;
        end
        low_cyc = cyc;
        check_eq("stall_low", 32'(stall), 32'd0);
        while (res_q.size() > 0) begin
            r = res_q.pop_front();
            case (r.kind)
                0:       check_eq(r.tag, if_rdata, r.val);
                1:       check_eq(r.tag, mem_rdata, r.val);
                2:       check_eq(r.tag, 32'(timeout_err), r.val);
                default: check_eq(r.tag, low_cyc, r.val);
            endcase
        end
    endtask

    // RAM responder: checks each command against the expected queue and answers after its latency
    initial begin
        cmd_t cur;
        int   cnt;
        cnt = 0;
        ram_done = 1'b0;
        ram_rdata = 32'd0;
        cur.addr = 32'd0; cur.we = 1'b0; cur.wdata = 32'd0; cur.cyc = 0; cur.lat = 0;
        forever begin
            @(posedge clk);
            #1;
            ram_done = 1'b0;
            ram_rdata = $urandom;
            if (cnt > 0) begin
                if (rst) begin
                    check_eq("hold_addr", ram_addr, cur.addr);
                    check_eq("hold_we", 32'(ram_we), 32'(cur.we));
                    if (cur.we) check_eq("hold_wdata", ram_wdata, cur.wdata);
                end
                cnt--;
                if (cnt == 0) begin
                    ram_done = 1'b1;
                    ram_rdata = ram_read(cur.addr);
                end
            end
            if (ram_en) begin
                if (cmd_q.size() == 0) begin
                    check_eq("unexpected_ram_en", 32'(ram_en), 32'd0);
                end else begin
                    cur = cmd_q.pop_front();
                    check_eq("ram_addr", ram_addr, cur.addr);
                    check_eq("ram_we", 32'(ram_we), 32'(cur.we));
                    if (cur.we) check_eq("ram_wdata", ram_wdata, cur.wdata);
                    check_eq("ram_en_cycle", cyc, cur.cyc);
                    cnt = cur.lat;
                    if (cur.we) ram_mem[cur.addr] = cur.wdata;
                end
            end
        end
    end

    initial begin
        ram_mem[32'h40]  = 32'h8C220004;
        ram_mem[32'h44]  = 32'h24010007;
        ram_mem[32'h48]  = 32'hAC430008;
        ram_mem[32'h50]  = 32'h3C011234;
        ram_mem[32'h80]  = 32'h08000020;
        ram_mem[32'h100] = 32'h0BADF00D;
        ram_mem[32'h300] = 32'h11111111;

        rst = 1'b0;
        if_req = 1'b0; if_addr = 32'd0; if_flush = 1'b0;
        mem_rd = 1'b0; mem_wr = 1'b0; mem_addr = 32'd0; mem_wdata = 32'd0;

        // Reset state and stall during reset
        #2;
        if_req = 1'b1;
        #1;
        check_eq("rst_stall_ifreq", 32'(stall), 32'd1);
        if_req = 1'b0;
        #1;
        check_eq("rst_stall_idle", 32'(stall), 32'd0);
        check_eq("rst_ram_en", 32'(ram_en), 32'd0);
        check_eq("rst_ram_we", 32'(ram_we), 32'd0);
        check_eq("rst_ram_addr", ram_addr, 32'd0);
        check_eq("rst_if_rdata", if_rdata, 32'd0);
        check_eq("rst_mem_rdata", mem_rdata, 32'd0);
        check_eq("rst_timeout_err", 32'(timeout_err), 32'd0);
        repeat (2) @(posedge clk);
        #3;
        rst = 1'b1;

        // Fetch only
        drive(1'b0, 1'b0, 1'b1, 32'h40, 32'd0, 32'd0);
        exp_cmd(32'h40, 1'b0, 32'd0, n_start + 1, 1);
        exp_res("fetch_if_rdata", 0, 32'h8C220004);
        exp_res("fetch_low_cycle", 3, n_start + 3);
        wait_done();

        // lw + fetch collision, issued the cycle after the previous advance
        drive(1'b1, 1'b0, 1'b1, 32'h44, 32'h100, 32'd0);
        exp_cmd(32'h100, 1'b0, 32'd0, n_start + 1, 1);
        exp_cmd(32'h44, 1'b0, 32'd0, n_start + 4, 1);
        exp_res("lw_mem_rdata", 1, 32'h0BADF00D);
        exp_res("lw_if_rdata", 0, 32'h24010007);
        exp_res("lw_low_cycle", 3, n_start + 6);
        wait_done();

        // sw: write held for the whole access, load buffer untouched
        drive(1'b0, 1'b1, 1'b0, 32'd0, 32'h200, 32'h12345678);
        exp_cmd(32'h200, 1'b1, 32'h12345678, n_start + 1, 2);
        exp_res("sw_mem_rdata", 1, 32'h0BADF00D);
        exp_res("sw_low_cycle", 3, n_start + 4);
        wait_done();

        // Flush one cycle after ram_en, PC redirected to 0x80
        drive(1'b0, 1'b0, 1'b1, 32'h48, 32'd0, 32'd0);
        exp_cmd(32'h48, 1'b0, 32'd0, n_start + 1, 3);
        @(posedge clk);
        @(posedge clk);
        #1;
        if_flush = 1'b1;
        if_addr = 32'h80;
        exp_cmd(32'h80, 1'b0, 32'd0, n_start + 6, 1);
        exp_res("flush_if_rdata", 0, 32'h08000020);
        exp_res("flush_low_cycle", 3, n_start + 8);
        @(posedge clk);
        #1;
        if_flush = 1'b0;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        check_eq("flush_dropped", if_rdata, 32'h24010007);
        wait_done();

        // Watchdog timeout on a load; late ram_done must be ignored
        drive(1'b1, 1'b0, 1'b0, 32'd0, 32'h300, 32'd0);
        exp_cmd(32'h300, 1'b0, 32'd0, n_start + 1, 20);
        exp_res("tmo_mem_rdata", 1, 32'hDEADBEEF);
        exp_res("tmo_err", 2, 32'd1);
        exp_res("tmo_low_cycle", 3, n_start + 17);
        wait_done();
        drive(1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 32'd0);
        repeat (8) @(posedge clk);
        @(negedge clk);
        check_eq("late_done_mem_rdata", mem_rdata, 32'hDEADBEEF);
        check_eq("tmo_err_sticky", 32'(timeout_err), 32'd1);

        // Asynchronous reset in the middle of a data access
        drive(1'b1, 1'b0, 1'b1, 32'h50, 32'h104, 32'd0);
        exp_cmd(32'h104, 1'b0, 32'd0, n_start + 1, 3);
        @(posedge clk);
        #3;
        rst = 1'b0;
        mem_rd = 1'b0;
        #1;
        check_eq("arst_ram_en", 32'(ram_en), 32'd0);
        check_eq("arst_ram_we", 32'(ram_we), 32'd0);
        check_eq("arst_ram_addr", ram_addr, 32'd0);
        check_eq("arst_ram_wdata", ram_wdata, 32'd0);
        check_eq("arst_if_rdata", if_rdata, 32'd0);
        check_eq("arst_mem_rdata", mem_rdata, 32'd0);
        check_eq("arst_timeout_err", 32'(timeout_err), 32'd0);
        check_eq("arst_stall", 32'(stall), 32'd1);
        repeat (4) @(posedge clk);
        #3;
        rst = 1'b1;
        exp_cmd(32'h50, 1'b0, 32'd0, n_start + 6, 1);
        exp_res("rearb_if_rdata", 0, 32'h3C011234);
        exp_res("rearb_low_cycle", 3, n_start + 8);
        wait_done();

        drive(1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 32'd0);
        repeat (5) @(posedge clk);
        #1;
        check_eq("cmd_queue_drained", cmd_q.size(), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
